// File: rtl/camera_ctrl.sv
// camera_ctrl: once per frame, samples the character's absolute Y position, divides its
// centre by the screen-block height (iterative subtraction), applies hysteresis to
// single-block moves and commits the resulting camera block index during blanking.
//
// Ports:
//   sys_clk        system clock
//   sys_rst        synchronous reset, active-high
//   frame_end      one-cycle pulse at start of vertical blanking
//   char_abs_y     character absolute Y (top edge)
//   camera_y       committed camera block index (to pixel_gen)
//   camera_change  one-cycle pulse when camera_y takes a new value
//   busy           high while a computation is in progress
//   frame_overrun  sticky: frame_end arrived while busy
module camera_ctrl #(
  parameter int unsigned PHY_WIDTH    = 14,
  parameter int unsigned BLOCK_WIDTH  = 480,
  parameter int unsigned CHAR_WIDTH_Y = 52,
  parameter int unsigned CAM_WIDTH    = 5,
  parameter int unsigned MAX_BLOCK    = 31,
  parameter int unsigned HYST         = 8
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 frame_end,
  input  logic [PHY_WIDTH-1:0] char_abs_y,
  output logic [CAM_WIDTH-1:0] camera_y,
  output logic                 camera_change,
  output logic                 busy,
  output logic                 frame_overrun
);

  // Centre needs one extra bit so y + CHAR_WIDTH_Y/2 never overflows.
  localparam int unsigned RW   = PHY_WIDTH + 1;
  localparam int unsigned QMax = ((1 << RW) + BLOCK_WIDTH - 1) / BLOCK_WIDTH;
  localparam int unsigned QW   = $clog2(QMax + 1);

  localparam logic [RW-1:0]        BlockW   = RW'(BLOCK_WIDTH);
  localparam logic [RW-1:0]        HalfChar = RW'(CHAR_WIDTH_Y / 2);
  localparam logic [RW-1:0]        HystLo   = RW'(HYST);
  localparam logic [RW-1:0]        HystHi   = RW'(BLOCK_WIDTH - 1 - HYST);
  localparam logic [QW-1:0]        MaxQ     = QW'(MAX_BLOCK);
  localparam logic [CAM_WIDTH-1:0] MaxCam   = CAM_WIDTH'(MAX_BLOCK);

  typedef enum logic [1:0] {StIdle, StDiv, StDecide} state_e;

  state_e               state_q, state_d;
  logic [RW-1:0]        r_q, r_d;
  logic [QW-1:0]        q_q, q_d;
  logic [CAM_WIDTH-1:0] cam_q, cam_d;
  logic                 change_q, change_d;
  logic                 busy_q, busy_d;
  logic                 overrun_q, overrun_d;

  // Decision terms, only consumed in StDecide.
  logic                 clamp;
  logic [CAM_WIDTH-1:0] qc;
  logic [CAM_WIDTH:0]   qc_x, cam_x;
  logic                 accept;

  always_comb begin
    clamp = (q_q > MaxQ);
    qc    = clamp ? MaxCam : CAM_WIDTH'(q_q);
    // One extra bit so +1 comparisons cannot wrap at the top/bottom block.
    qc_x  = {1'b0, qc};
    cam_x = {1'b0, cam_q};
    if (clamp) begin
      accept = 1'b1;
    end else if (qc_x == cam_x) begin
      accept = 1'b0;
    end else if (qc_x == cam_x + 1'b1) begin
      accept = (r_q >= HystLo);
    end else if (qc_x + 1'b1 == cam_x) begin
      accept = (r_q <= HystHi);
    end else begin
      accept = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    q_d       = q_q;
    cam_d     = cam_q;
    change_d  = 1'b0;
    overrun_d = overrun_q | (frame_end && (state_q != StIdle));

    unique case (state_q)
      StIdle: begin
        if (frame_end) begin
          r_d     = {1'b0, char_abs_y} + HalfChar;
          q_d     = '0;
          state_d = StDiv;
        end
      end
      StDiv: begin
        if (r_q >= BlockW) begin
          r_d = r_q - BlockW;
          q_d = q_q + 1'b1;
        end else begin
          state_d = StDecide;
        end
      end
      StDecide: begin
        state_d = StIdle;
        if (accept && (qc != cam_q)) begin
          cam_d    = qc;
          change_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= StIdle;
      r_q       <= '0;
      q_q       <= '0;
      cam_q     <= '0;
      change_q  <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      q_q       <= q_d;
      cam_q     <= cam_d;
      change_q  <= change_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign camera_y      = cam_q;
  assign camera_change = change_q;
  assign busy          = busy_q;
  assign frame_overrun = overrun_q;

endmodule

// File: tb/tb_camera_ctrl.sv
// Self-checking bench for camera_ctrl: table of directed frames, hand-written overrun and
// reset sequences, then randomized frames checked against an arithmetic reference model.
module tb_camera_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic        frame_end = 1'b0;
  logic [13:0] char_abs_y = '0;
  logic [4:0]  camera_y;
  logic        camera_change;
  logic        busy;
  logic        frame_overrun;

  int checks = 0;
  int failures = 0;

  camera_ctrl dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .frame_end    (frame_end),
    .char_abs_y   (char_abs_y),
    .camera_y     (camera_y),
    .camera_change(camera_change),
    .busy         (busy),
    .frame_overrun(frame_overrun)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int y;
    int exp_cam;
    int exp_pulse;
    int exp_lat;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs are driven and outputs sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    frame_end = 1'b0;
    tick();
    sys_rst = 1'b0;
  endtask

  // Reference: centre / block with hysteresis, straight from the rules.
  function automatic void model(input int y, input int cam, output int ncam, output int q);
    int c, r, qc;
    bit acc;
    c  = y + 26;
    q  = c / 480;
    r  = c % 480;
    qc = (q > 31) ? 31 : q;
    if (q > 31)            acc = 1;
    else if (qc == cam)     acc = 0;
    else if (qc == cam + 1) acc = (r >= 8);
    else if (qc == cam - 1) acc = (r <= 471);
    else                    acc = 1;
    ncam = acc ? qc : cam;
  endfunction

  // Runs one frame; char_abs_y is scrambled after E0 to prove it is only sampled once.
  task automatic do_frame(input int y, output int chg_edge, output int npulse,
                          output int nbusy, output int stable_ok, output int done);
    logic [4:0] prev;
    int idle_cnt;
    char_abs_y = 14'(y);
    frame_end = 1'b1;
    prev = camera_y;
    tick();  // E0
    frame_end = 1'b0;
    char_abs_y = 14'($urandom);
    chg_edge = -1; npulse = 0; nbusy = 0; stable_ok = 1; idle_cnt = 0; done = 0;
    for (int k = 0; k < 80; k++) begin
      if (k > 0) tick();
      if (camera_change) begin
        npulse++;
        chg_edge = k;
      end
      if ((camera_y != prev) != camera_change) stable_ok = 0;
      prev = camera_y;
      if (busy) nbusy++;
      else idle_cnt++;
      if (idle_cnt == 2) begin
        done = 1;
        break;
      end
    end
  endtask

  task automatic run_checked(input string tag, input int y, input int exp_cam,
                             input int exp_pulse, input int exp_lat);
    int ce, np, nb, st, dn;
    do_frame(y, ce, np, nb, st, dn);
    chk({tag, " done"}, dn, 1);
    chk({tag, " camera_y"}, int'(camera_y), exp_cam);
    chk({tag, " pulses"}, np, exp_pulse);
    chk({tag, " busy_cycles"}, nb, exp_lat);
    if (exp_pulse != 0) chk({tag, " commit_edge"}, ce, exp_lat);
    chk({tag, " stable"}, st, 1);
  endtask

  initial begin
    vec_t vecs[$];
    int cam_m, ncam, q, y;

    vecs.push_back('{y: 100,   exp_cam: 0,  exp_pulse: 0, exp_lat: 2});
    vecs.push_back('{y: 460,   exp_cam: 0,  exp_pulse: 0, exp_lat: 3});
    vecs.push_back('{y: 470,   exp_cam: 1,  exp_pulse: 1, exp_lat: 3});
    vecs.push_back('{y: 450,   exp_cam: 1,  exp_pulse: 0, exp_lat: 2});
    vecs.push_back('{y: 440,   exp_cam: 0,  exp_pulse: 1, exp_lat: 2});
    vecs.push_back('{y: 2000,  exp_cam: 4,  exp_pulse: 1, exp_lat: 6});
    vecs.push_back('{y: 16383, exp_cam: 31, exp_pulse: 1, exp_lat: 36});
    vecs.push_back('{y: 14860, exp_cam: 31, exp_pulse: 0, exp_lat: 33});
    vecs.push_back('{y: 0,     exp_cam: 0,  exp_pulse: 1, exp_lat: 2});

    do_reset();
    tick();
    chk("reset camera_y", int'(camera_y), 0);
    chk("reset change", int'(camera_change), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset overrun", int'(frame_overrun), 0);

    foreach (vecs[i]) begin
      run_checked($sformatf("vec%0d", i), vecs[i].y, vecs[i].exp_cam, vecs[i].exp_pulse,
                  vecs[i].exp_lat);
    end
    chk("table overrun", int'(frame_overrun), 0);

    // Overrun mid-DIV: second pulse ignored, result unaffected.
    do_reset();
    char_abs_y = 14'd2000;
    frame_end = 1'b1;
    tick();  // E0
    frame_end = 1'b0;
    tick();  // E0+1
    chk("ovr not yet", int'(frame_overrun), 0);
    frame_end = 1'b1;
    tick();  // E0+2
    frame_end = 1'b0;
    chk("ovr set", int'(frame_overrun), 1);
    chk("ovr busy", int'(busy), 1);
    tick(); tick(); tick();  // E0+5
    chk("ovr cam before", int'(camera_y), 0);
    tick();  // E0+6
    chk("ovr cam commit", int'(camera_y), 4);
    chk("ovr change", int'(camera_change), 1);
    chk("ovr busy end", int'(busy), 0);
    tick();
    chk("ovr change drop", int'(camera_change), 0);
    chk("ovr sticky", int'(frame_overrun), 1);
    chk("ovr cam hold", int'(camera_y), 4);

    // frame_end on the DECIDE -> IDLE edge is an overrun and starts nothing.
    do_reset();
    char_abs_y = 14'd100;
    frame_end = 1'b1;
    tick();  // E0
    frame_end = 1'b0;
    tick();  // E0+1, DECIDE
    frame_end = 1'b1;
    tick();  // E0+2
    frame_end = 1'b0;
    chk("decide ovr", int'(frame_overrun), 1);
    chk("decide busy", int'(busy), 0);
    tick();
    chk("decide no start", int'(busy), 0);

    // Reset during DIV clears everything; next frame computes normally.
    do_reset();
    run_checked("pre_rst", 2000, 4, 1, 6);
    char_abs_y = 14'd16383;
    frame_end = 1'b1;
    tick();  // E0
    frame_end = 1'b0;
    tick();
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    chk("rst ovr set", int'(frame_overrun), 1);
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    chk("rst cam", int'(camera_y), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst ovr", int'(frame_overrun), 0);
    chk("rst change", int'(camera_change), 0);
    tick(); tick();
    chk("rst stays idle", int'(busy), 0);
    run_checked("post_rst", 2000, 4, 1, 6);

    // Randomized frames against the reference model.
    cam_m = int'(camera_y);
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(2) == 0) begin
        y = int'($urandom_range(16383));
      end else begin
        y = (cam_m + int'($urandom_range(2)) - 1 + 1) * 480 - 26 + int'($urandom_range(40)) - 20;
        if (y < 0) y = 0;
        if (y > 16383) y = 16383;
      end
      model(y, cam_m, ncam, q);
      run_checked($sformatf("rnd%0d y=%0d", n, y), y, ncam, (ncam != cam_m) ? 1 : 0, q + 2);
      cam_m = ncam;
    end
    chk("rnd overrun", int'(frame_overrun), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
